// File: rtl/saxi_full_mem.sv
// AXI4-Full slave memory model: independent write and read engines over one word-addressed array.
// Every burst completes with OKAY; high address bits above MEM_ADDR_BITS alias.
module saxi_full_mem #(
    parameter int C_S_AXI_ID_WIDTH     = 1,
    parameter int C_S_AXI_DATA_WIDTH   = 64,
    parameter int C_S_AXI_ADDR_WIDTH   = 32,
    parameter int C_S_AXI_AWUSER_WIDTH = 0,
    parameter int C_S_AXI_ARUSER_WIDTH = 0,
    parameter int C_S_AXI_WUSER_WIDTH  = 0,
    parameter int C_S_AXI_RUSER_WIDTH  = 0,
    parameter int C_S_AXI_BUSER_WIDTH  = 0,
    parameter int MEM_ADDR_BITS        = 24
) (
    input  logic                                  S_AXI_ACLK,
    input  logic                                  S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]           S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_AWADDR,
    input  logic [7:0]                            S_AXI_AWLEN,
    input  logic [2:0]                            S_AXI_AWSIZE,
    input  logic [1:0]                            S_AXI_AWBURST,
    input  logic                                  S_AXI_AWLOCK,
    input  logic [3:0]                            S_AXI_AWCACHE,
    input  logic [2:0]                            S_AXI_AWPROT,
    input  logic [3:0]                            S_AXI_AWQOS,
    input  logic [3:0]                            S_AXI_AWREGION,
    input  logic [((C_S_AXI_AWUSER_WIDTH > 0) ? C_S_AXI_AWUSER_WIDTH : 1)-1:0] S_AXI_AWUSER,
    input  logic                                  S_AXI_AWVALID,
    output logic                                  S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]       S_AXI_WSTRB,
    input  logic                                  S_AXI_WLAST,
    input  logic [((C_S_AXI_WUSER_WIDTH > 0) ? C_S_AXI_WUSER_WIDTH : 1)-1:0] S_AXI_WUSER,
    input  logic                                  S_AXI_WVALID,
    output logic                                  S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]           S_AXI_BID,
    output logic [1:0]                            S_AXI_BRESP,
    output logic [((C_S_AXI_BUSER_WIDTH > 0) ? C_S_AXI_BUSER_WIDTH : 1)-1:0] S_AXI_BUSER,
    output logic                                  S_AXI_BVALID,
    input  logic                                  S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]           S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_ARADDR,
    input  logic [7:0]                            S_AXI_ARLEN,
    input  logic [2:0]                            S_AXI_ARSIZE,
    input  logic [1:0]                            S_AXI_ARBURST,
    input  logic                                  S_AXI_ARLOCK,
    input  logic [3:0]                            S_AXI_ARCACHE,
    input  logic [2:0]                            S_AXI_ARPROT,
    input  logic [3:0]                            S_AXI_ARQOS,
    input  logic [3:0]                            S_AXI_ARREGION,
    input  logic [((C_S_AXI_ARUSER_WIDTH > 0) ? C_S_AXI_ARUSER_WIDTH : 1)-1:0] S_AXI_ARUSER,
    input  logic                                  S_AXI_ARVALID,
    output logic                                  S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]           S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_RDATA,
    output logic [1:0]                            S_AXI_RRESP,
    output logic                                  S_AXI_RLAST,
    output logic [((C_S_AXI_RUSER_WIDTH > 0) ? C_S_AXI_RUSER_WIDTH : 1)-1:0] S_AXI_RUSER,
    output logic                                  S_AXI_RVALID,
    input  logic                                  S_AXI_RREADY
);

    localparam int AW        = C_S_AXI_ADDR_WIDTH;
    localparam int DW        = C_S_AXI_DATA_WIDTH;
    localparam int NB        = DW / 8;
    localparam int LANE_BITS = $clog2(NB);
    localparam int IDX_W     = MEM_ADDR_BITS - LANE_BITS;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DW-1:0] mem [0:(2**IDX_W)-1];

    w_state_t                    w_state_q;
    logic                        awready_q, wready_q, bvalid_q;
    logic [C_S_AXI_ID_WIDTH-1:0] w_id_q;
    logic [AW-1:0]               w_addr_q, w_addr_d;
    logic [7:0]                  w_len_q, w_cnt_q;
    logic [2:0]                  w_size_q;
    logic [1:0]                  w_burst_q;

    r_state_t                    r_state_q;
    logic                        arready_q, rvalid_q, rlast_q;
    logic [C_S_AXI_ID_WIDTH-1:0] r_id_q;
    logic [AW-1:0]               r_addr_q, r_addr_d;
    logic [7:0]                  r_len_q, r_cnt_q;
    logic [2:0]                  r_size_q;
    logic [1:0]                  r_burst_q;
    logic [DW-1:0]               rdata_q;

    logic w_fire;

    // WRAP window is (len+1) beats of 2**size bytes; len is a power of two minus one for legal wraps.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [7:0] len,
                                                input logic [2:0] size, input logic [1:0] burst);
        logic [AW-1:0] step;
        logic [AW-1:0] wmask;
        logic [AW-1:0] res;
        step  = AW'(1) << size;
        wmask = ((AW'(len) + AW'(1)) << size) - AW'(1);
        case (burst)
            2'b00:   res = a;
            2'b10:   res = (a & ~wmask) | ((a + step) & wmask);
            default: res = a + step;
        endcase
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] a);
        return a[MEM_ADDR_BITS-1:LANE_BITS];
    endfunction

    assign w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
    assign r_addr_d = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
    assign w_fire   = wready_q && S_AXI_WVALID;

    always_ff @(posedge S_AXI_ACLK) begin
        if (w_fire) begin
            for (int b = 0; b < NB; b++) begin
                if (S_AXI_WSTRB[b]) mem[word_idx(w_addr_q)][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (awready_q && S_AXI_AWVALID) begin
                        w_id_q    <= S_AXI_AWID;
                        w_addr_q  <= S_AXI_AWADDR;
                        w_len_q   <= S_AXI_AWLEN;
                        w_size_q  <= S_AXI_AWSIZE;
                        w_burst_q <= S_AXI_AWBURST;
                        w_cnt_q   <= '0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    // Burst length comes from AWLEN alone; WLAST is not trusted.
                    if (w_fire) begin
                        w_addr_q <= w_addr_d;
                        w_cnt_q  <= w_cnt_q + 8'd1;
                        if (w_cnt_q == w_len_q) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            rdata_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (arready_q && S_AXI_ARVALID) begin
                        r_id_q    <= S_AXI_ARID;
                        r_addr_q  <= S_AXI_ARADDR;
                        r_len_q   <= S_AXI_ARLEN;
                        r_size_q  <= S_AXI_ARSIZE;
                        r_burst_q <= S_AXI_ARBURST;
                        r_cnt_q   <= '0;
                        rdata_q   <= mem[word_idx(S_AXI_ARADDR)];
                        rlast_q   <= (S_AXI_ARLEN == 8'd0);
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state_q <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    // Registered read sees the array before any same-cycle write lands.
                    if (S_AXI_RREADY) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            r_addr_q <= r_addr_d;
                            r_cnt_q  <= r_cnt_q + 8'd1;
                            rdata_q  <= mem[word_idx(r_addr_d)];
                            rlast_q  <= ((r_cnt_q + 8'd1) == r_len_q);
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BID     = w_id_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BUSER   = '0;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RID     = r_id_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RUSER   = '0;

    logic unused_ok;
    assign unused_ok = &{1'b0, S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWREGION,
                         S_AXI_AWUSER, S_AXI_WLAST, S_AXI_WUSER, S_AXI_ARLOCK, S_AXI_ARCACHE,
                         S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARREGION, S_AXI_ARUSER};

endmodule

// File: tb/tb_saxi_full_mem.sv
// Directed bench for saxi_full_mem: single-beat vector table plus burst, backpressure,
// concurrency, WRAP/FIXED, aliasing and mid-burst reset sequences.
module tb_saxi_full_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:0]  AWID = '0, ARID = '0;
    logic [31:0] AWADDR = '0, ARADDR = '0;
    logic [7:0]  AWLEN = '0, ARLEN = '0;
    logic [2:0]  AWSIZE = '0, ARSIZE = '0;
    logic [1:0]  AWBURST = '0, ARBURST = '0;
    logic        AWVALID = 1'b0, ARVALID = 1'b0;
    logic [63:0] WDATA = '0;
    logic [7:0]  WSTRB = '0;
    logic        WLAST = 1'b0, WVALID = 1'b0, BREADY = 1'b0, RREADY = 1'b0;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST;
    logic [0:0]  BID, RID, BUSER, RUSER;
    logic [1:0]  BRESP, RRESP;
    logic [63:0] RDATA;

    int checks = 0;
    int errors = 0;

    logic [63:0] wbuf [16];
    logic [7:0]  sbuf [16];
    logic [63:0] rbuf [16];
    logic        rlb  [16];
    logic [1:0]  last_bresp;
    logic [0:0]  last_bid;

    always #5 clk = ~clk;

    saxi_full_mem dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWID(AWID), .S_AXI_AWADDR(AWADDR), .S_AXI_AWLEN(AWLEN), .S_AXI_AWSIZE(AWSIZE),
        .S_AXI_AWBURST(AWBURST), .S_AXI_AWLOCK(1'b0), .S_AXI_AWCACHE(4'd0), .S_AXI_AWPROT(3'd0),
        .S_AXI_AWQOS(4'd0), .S_AXI_AWREGION(4'd0), .S_AXI_AWUSER(1'b0),
        .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WLAST(WLAST), .S_AXI_WUSER(1'b0),
        .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BID(BID), .S_AXI_BRESP(BRESP), .S_AXI_BUSER(BUSER), .S_AXI_BVALID(BVALID),
        .S_AXI_BREADY(BREADY),
        .S_AXI_ARID(ARID), .S_AXI_ARADDR(ARADDR), .S_AXI_ARLEN(ARLEN), .S_AXI_ARSIZE(ARSIZE),
        .S_AXI_ARBURST(ARBURST), .S_AXI_ARLOCK(1'b0), .S_AXI_ARCACHE(4'd0), .S_AXI_ARPROT(3'd0),
        .S_AXI_ARQOS(4'd0), .S_AXI_ARREGION(4'd0), .S_AXI_ARUSER(1'b0),
        .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RID(RID), .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RLAST(RLAST),
        .S_AXI_RUSER(RUSER), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=handshake", name);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [0:0] id, input int bwait);
        int t;
        @(negedge clk);
        AWVALID = 1'b1; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWID = id;
        t = 0;
        while (!AWREADY && t < 100) begin @(negedge clk); t++; end
        if (!AWREADY) begin timeout("aw_wait"); AWVALID = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        AWVALID = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            WVALID = 1'b1; WDATA = wbuf[b]; WSTRB = sbuf[b]; WLAST = (b == int'(len));
            t = 0;
            while (!WREADY && t < 100) begin @(negedge clk); t++; end
            if (!WREADY) begin timeout("w_wait"); WVALID = 1'b0; return; end
            chk("aw_blocked_during_w", AWREADY, 0);
            @(posedge clk);
            @(negedge clk);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        chk("b_latency", BVALID, 1);
        for (int i = 0; i < bwait; i++) begin
            @(negedge clk);
            chk("b_held", BVALID, 1);
            chk("aw_held_off", AWREADY, 0);
        end
        BREADY = 1'b1;
        last_bresp = BRESP;
        last_bid = BID;
        @(posedge clk);
        @(negedge clk);
        BREADY = 1'b0;
        chk("b_done", BVALID, 0);
        chk("aw_reopen", AWREADY, 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [0:0] id, input bit stall);
        int t;
        logic [63:0] d;
        logic l;
        @(negedge clk);
        ARVALID = 1'b1; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARID = id;
        t = 0;
        while (!ARREADY && t < 100) begin @(negedge clk); t++; end
        if (!ARREADY) begin timeout("ar_wait"); ARVALID = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        ARVALID = 1'b0;
        chk("r_latency", RVALID, 1);
        for (int b = 0; b <= int'(len); b++) begin
            t = 0;
            while (!RVALID && t < 100) begin @(negedge clk); t++; end
            if (!RVALID) begin timeout("r_wait"); RREADY = 1'b0; return; end
            if (stall) begin
                RREADY = 1'b0;
                d = RDATA;
                l = RLAST;
                @(negedge clk);
                chk("r_stall_valid", RVALID, 1);
                chk("r_stall_data", RDATA, d);
                chk("r_stall_last", RLAST, l);
            end
            rbuf[b] = RDATA;
            rlb[b]  = RLAST;
            chk("rid", RID, id);
            chk("rresp", RRESP, 0);
            RREADY = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        RREADY = 1'b0;
        chk("r_idle", RVALID, 0);
        chk("ar_reopen", ARREADY, 1);
    endtask

    task automatic rd1(input string name, input logic [31:0] addr, input logic [63:0] exp);
        do_read(addr, 8'd0, 3'd3, 2'b01, 1'b0, 1'b0);
        chk(name, rbuf[0], exp);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [7:0]  strb;
        logic [0:0]  id;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{32'h1000_0000, 3'd3, 64'h1122_3344_5566_7788, 8'hFF, 1'b0, 64'h1122_3344_5566_7788};
        vecs[1] = '{32'h0000_0200, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[2] = '{32'h0000_0200, 3'd3, 64'h0000_0000_0000_0000, 8'h0F, 1'b0, 64'hFFFF_FFFF_0000_0000};
        vecs[3] = '{32'h0000_0200, 3'd3, 64'hAAAA_AAAA_AAAA_AAAA, 8'h80, 1'b1, 64'hAAFF_FFFF_0000_0000};
        vecs[4] = '{32'h0100_0200, 3'd3, 64'h0000_0000_0000_0012, 8'h01, 1'b0, 64'hAAFF_FFFF_0000_0012};
        vecs[5] = '{32'h0000_0204, 3'd2, 64'h5555_5555_0000_0000, 8'hF0, 1'b1, 64'h5555_5555_0000_0012};
        vecs[6] = '{32'h1000_0008, 3'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 64'h0123_4567_89AB_CDEF};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rlast", RLAST, 0);
        chk("rst_rdata", RDATA, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_awready", AWREADY, 1);
        chk("rel_arready", ARREADY, 1);

        // single-beat vectors: strobes, aliasing, narrow beats
        foreach (vecs[k]) begin
            wbuf[0] = vecs[k].wdata;
            sbuf[0] = vecs[k].strb;
            do_write(vecs[k].addr, 8'd0, vecs[k].size, 2'b01, vecs[k].id, 0);
            chk("vec_bresp", last_bresp, 0);
            chk("vec_bid", last_bid, vecs[k].id);
            do_read(vecs[k].addr, 8'd0, vecs[k].size, 2'b01, vecs[k].id, 1'b0);
            chk("vec_rdata", rbuf[0], vecs[k].exp);
            chk("vec_rlast", rlb[0], 1);
        end

        for (int i = 0; i < 16; i++) sbuf[i] = 8'hFF;

        // INCR len15
        for (int i = 0; i < 16; i++) wbuf[i] = 64'(i);
        do_write(32'h1000_0080, 8'd15, 3'd3, 2'b01, 1'b1, 0);
        chk("incr_bid", last_bid, 1);
        do_read(32'h1000_0080, 8'd15, 3'd3, 2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk("incr_rdata", rbuf[i], 64'(i));
            chk("incr_rlast", rlb[i], (i == 15) ? 1 : 0);
        end

        // backpressure on B and R
        for (int i = 0; i < 4; i++) wbuf[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
        do_write(32'h0000_0600, 8'd3, 3'd3, 2'b01, 1'b0, 5);
        chk("bp_bresp", last_bresp, 0);
        do_read(32'h0000_0600, 8'd3, 3'd3, 2'b01, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_rdata", rbuf[i], 64'hC0DE_0000_0000_0000 + 64'(i));
            chk("bp_rlast", rlb[i], (i == 3) ? 1 : 0);
        end

        // concurrent write and read to disjoint regions
        for (int i = 0; i < 16; i++) wbuf[i] = 64'h100 + 64'(i);
        fork
            do_write(32'h0000_2000, 8'd15, 3'd3, 2'b01, 1'b1, 2);
            do_read(32'h1000_0080, 8'd15, 3'd3, 2'b01, 1'b0, 1'b0);
        join
        for (int i = 0; i < 16; i++) chk("conc_rdata", rbuf[i], 64'(i));
        do_read(32'h0000_2000, 8'd15, 3'd3, 2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) chk("conc_wback", rbuf[i], 64'h100 + 64'(i));

        // WRAP len3 size3 starting at offset 0x18 of a 32-byte window
        for (int i = 0; i < 4; i++) wbuf[i] = 64'hAAAA_0000_0000_0000 + 64'(i);
        do_write(32'h0000_0318, 8'd3, 3'd3, 2'b10, 1'b0, 0);
        rd1("wrap_0x318", 32'h0000_0318, 64'hAAAA_0000_0000_0000);
        rd1("wrap_0x300", 32'h0000_0300, 64'hAAAA_0000_0000_0001);
        rd1("wrap_0x308", 32'h0000_0308, 64'hAAAA_0000_0000_0002);
        rd1("wrap_0x310", 32'h0000_0310, 64'hAAAA_0000_0000_0003);
        do_read(32'h0000_0318, 8'd3, 3'd3, 2'b10, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) chk("wrap_rd", rbuf[i], 64'hAAAA_0000_0000_0000 + 64'(i));

        // FIXED: all beats hit one word, last wins; neighbour untouched
        wbuf[0] = 64'h5E5E_5E5E_5E5E_5E5E;
        do_write(32'h0000_0408, 8'd0, 3'd3, 2'b01, 1'b0, 0);
        for (int i = 0; i < 4; i++) wbuf[i] = 64'hF0 + 64'(i);
        do_write(32'h0000_0400, 8'd3, 3'd3, 2'b00, 1'b0, 0);
        rd1("fixed_last_wins", 32'h0000_0400, 64'hF3);
        rd1("fixed_neighbour", 32'h0000_0408, 64'h5E5E_5E5E_5E5E_5E5E);
        do_read(32'h0000_0400, 8'd3, 3'd3, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) chk("fixed_rd", rbuf[i], 64'hF3);

        // burst type 3 behaves as INCR; INCR past top of array wraps to word 0
        wbuf[0] = 64'h7070; wbuf[1] = 64'h7171;
        do_write(32'h0000_0700, 8'd1, 3'd3, 2'b11, 1'b0, 0);
        rd1("burst3_beat1", 32'h0000_0708, 64'h7171);
        wbuf[0] = 64'hE0E0; wbuf[1] = 64'hE1E1;
        do_write(32'h00FF_FFF8, 8'd1, 3'd3, 2'b01, 1'b0, 0);
        rd1("top_wrap_word0", 32'h0000_0000, 64'hE1E1);
        rd1("top_word", 32'h00FF_FFF8, 64'hE0E0);

        // reset in the middle of a write burst
        @(negedge clk);
        chk("mid_aw_ready", AWREADY, 1);
        AWVALID = 1'b1; AWADDR = 32'h800; AWLEN = 8'd3; AWSIZE = 3'd3; AWBURST = 2'b01; AWID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        AWVALID = 1'b0;
        chk("mid_wready", WREADY, 1);
        WVALID = 1'b1; WDATA = 64'h1; WSTRB = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        WVALID = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wready", WREADY, 0);
        chk("mid_rst_awready", AWREADY, 0);
        chk("mid_rst_bvalid", BVALID, 0);
        chk("mid_rst_bid", BID, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_awready", AWREADY, 1);
        chk("mid_rel_wready", WREADY, 0);
        wbuf[0] = 64'h77;
        do_write(32'h0000_0800, 8'd0, 3'd3, 2'b01, 1'b0, 0);
        rd1("mid_after_reset", 32'h0000_0800, 64'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=stuck expected=finish");
        $fatal(1, "global timeout");
    end

endmodule
